usart_tx_buffer: RTL

Transmit-side data buffering for the USART; mirror of the receive buffer path. Double-buffers MCU writes to UDR: one holding register plus a hand-off into the transmit shift register. Generates the UDRE (data register empty) and TXC (transmit complete) status flags and a write-collision flag. Sits between the MCU bus interface and the transmit shift register/frame generator.

---
 rtl/usart_tx_buffer_if.sv | 30 +++
 rtl/usart_tx_buffer.sv | 112 +++++++++++
 2 files changed

// File: rtl/usart_tx_buffer_if.sv
// MCU-side and shift-register-side signals of the USART transmit buffer.
// The master drives the inputs and the slave (the buffer) returns the status and frame outputs.
interface usart_tx_buffer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  i_mcu_write;
   logic [DATA_WIDTH-1:0] i_udr_data;
   logic                  i_txb8;
   logic                  i_tx_enable;
   logic                  i_shift_ready;
   logic                  i_shift_done;
   logic                  i_txc_clear;
   logic [DATA_WIDTH:0]   o_shift_data;
   logic                  o_shift_load;
   logic                  o_udre;
   logic                  o_txc;
   logic                  o_write_collision;

   modport master (
      output i_mcu_write, i_udr_data, i_txb8, i_tx_enable,
      output i_shift_ready, i_shift_done, i_txc_clear,
      input  o_shift_data, o_shift_load, o_udre, o_txc, o_write_collision
   );

   modport slave (
      input  i_mcu_write, i_udr_data, i_txb8, i_tx_enable,
      input  i_shift_ready, i_shift_done, i_txc_clear,
      output o_shift_data, o_shift_load, o_udre, o_txc, o_write_collision
   );
endinterface

// File: rtl/usart_tx_buffer.sv
// USART transmit buffer: a single UDR holding register feeding the shift register.
// It also produces the UDRE, TXC and write-collision status flags.
module usart_tx_buffer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   usart_tx_buffer_if.slave  bus
);
   localparam int FRAME_W = DATA_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      BUSY = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [FRAME_W-1:0]   hold_data;
   logic [FRAME_W-1:0]   shift_data;
   logic                 udre;
   logic                 txc;
   logic                 collision;

   logic                 write_acc;
   logic                 write_rej;
   logic                 start;
   logic                 txc_set;

   // udre doubles as the "holding register empty" marker
   assign write_acc = bus.i_mcu_write &  udre;
   assign write_rej = bus.i_mcu_write & ~udre;

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      txc_set   = 1'b0;
      case (state)
         IDLE: begin
            if (!udre && bus.i_tx_enable && bus.i_shift_ready) begin
               state_nxt = LOAD;
               start     = 1'b1;
            end
         end
         LOAD: begin
            state_nxt = BUSY;
         end
         BUSY: begin
            if (bus.i_shift_done) begin
               state_nxt = IDLE;
               // TXC only when nothing is queued behind the finished frame
               txc_set   = udre & ~bus.i_mcu_write;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Holding register and hand-off to the shift register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         hold_data  <= '0;
         shift_data <= '0;
         udre       <= 1'b1;
      end else begin
         if (write_acc) begin
            hold_data <= {bus.i_txb8, bus.i_udr_data};
            udre      <= 1'b0;
         end else if (start) begin
            shift_data <= hold_data;
            udre       <= 1'b1;
         end
      end
   end

   // Status flags
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         txc       <= 1'b0;
         collision <= 1'b0;
      end else begin
         if (txc_set) begin
            txc <= 1'b1;
         end else if (bus.i_txc_clear) begin
            txc <= 1'b0;
         end

         if (write_acc) begin
            collision <= 1'b0;
         end else if (write_rej) begin
            collision <= 1'b1;
         end
      end
   end

   assign bus.o_shift_data      = shift_data;
   assign bus.o_shift_load      = (state == LOAD);
   assign bus.o_udre            = udre;
   assign bus.o_txc             = txc;
   assign bus.o_write_collision = collision;

endmodule
